uart_loader: RTL

Boot controller between `uart_receive` and the CPU's instruction/data memory write port. It parses a framed program image from the UART byte stream, assembles little-endian 32-bit words, and writes them sequentially into memory. The CPU is held in reset for the whole load. Reset is released only after a valid checksum, so new programs can be loaded without re-synthesizing `prog.mem`.

---
 rtl/loader_pkg.sv | 16 +
 rtl/uart_loader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared definitions for the UART program loader: the frame parser state
//   encoding and the default frame start byte.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

endpackage : loader_pkg

// File: rtl/uart_loader.sv
// uart_loader
//   Boot loader sitting between the UART receiver and the CPU memory write
//   port. Parses a framed image (MAGIC, LEN_LO, LEN_HI, 4*N payload bytes,
//   CSUM), assembles little-endian 32-bit words, writes them sequentially
//   starting at BASE_ADDR, and holds the CPU in reset until a frame with a
//   matching XOR checksum completes.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx_valid   in   single-cycle strobe, rx_byte valid this cycle
//   rx_byte    in   received UART byte
//   cpu_rst    out  hold-reset to the CPU (ORed with system reset outside)
//   mem_wen    out  single-cycle memory write strobe
//   mem_addr   out  word address of the write
//   mem_wdata  out  write data
//   busy       out  frame in progress
//   load_ok    out  sticky success flag
//   load_err   out  sticky failure flag (bad checksum or timeout)
//
// States
//   ST_IDLE   | waiting for MAGIC, all other bytes ignored
//   ST_LEN_LO | next byte is word count, low byte
//   ST_LEN_HI | next byte is word count, high byte
//   ST_DATA   | payload bytes, one word written every 4th byte
//   ST_CSUM   | next byte is compared against the running payload XOR
module uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  MAGIC          = LOADER_MAGIC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  cpu_rst,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  load_ok,
  output logic                  load_err
);

  // Idle-gap timer is a down-counter reloaded on every byte; reaching zero
  // while a frame is open is the timeout. Reloading with TIMEOUT_CYCLES-1
  // makes it expire TIMEOUT_CYCLES clocks after the last byte.
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  loader_state_t   state;
  logic [15:0]     len;
  logic [15:0]     word_idx;
  logic [1:0]      byte_idx;
  logic [7:0]      csum;
  logic [23:0]     asm_word;
  logic [TO_W-1:0] to_cnt;

  logic            timeout;
  logic [15:0]     len_full;

  // A byte arriving on the terminal-count cycle takes priority over the timeout.
  assign timeout  = (state != ST_IDLE) && !rx_valid && (to_cnt == '0);
  assign len_full = {rx_byte, len[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      csum      <= '0;
      asm_word  <= '0;
      to_cnt    <= '0;
      cpu_rst   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_wen <= 1'b0;

      if (rx_valid) begin
        to_cnt <= TO_LOAD;
      end else if ((state != ST_IDLE) && (to_cnt != '0)) begin
        to_cnt <= to_cnt - TO_W'(1);
      end

      if (timeout) begin
        // cpu_rst is already high from the MAGIC byte and stays there.
        state    <= ST_IDLE;
        busy     <= 1'b0;
        load_err <= 1'b1;
      end else if (rx_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (rx_byte == MAGIC) begin
              state    <= ST_LEN_LO;
              cpu_rst  <= 1'b1;
              busy     <= 1'b1;
              load_ok  <= 1'b0;
              load_err <= 1'b0;
              word_idx <= '0;
              byte_idx <= '0;
              csum     <= '0;
            end
          end

          ST_LEN_LO: begin
            len[7:0] <= rx_byte;
            state    <= ST_LEN_HI;
          end

          ST_LEN_HI: begin
            len[15:8] <= rx_byte;
            state     <= (len_full != 16'd0) ? ST_DATA : ST_CSUM;
          end

          ST_DATA: begin
            csum     <= csum ^ rx_byte;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: asm_word[7:0]   <= rx_byte;
              2'd1: asm_word[15:8]  <= rx_byte;
              2'd2: asm_word[23:16] <= rx_byte;
              2'd3: begin
                mem_wen   <= 1'b1;
                mem_wdata <= {rx_byte, asm_word};
                // Wraps modulo 2^ADDR_WIDTH; no range check on purpose.
                mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);
                word_idx  <= word_idx + 16'd1;
                if (word_idx == (len - 16'd1)) begin
                  state <= ST_CSUM;
                end
              end
              default: ;
            endcase
          end

          ST_CSUM: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (rx_byte == csum) begin
              load_ok <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              load_err <= 1'b1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule : uart_loader
